// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline around the ID/EX register.
// Produces stage write enables, the IF/ID flush, the ID/EX bubble, halt drain and a stall counter.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_Rs,
    input  logic [2:0]       id_Rt,
    input  logic             id_RsValid,
    input  logic             id_RtValid,
    input  logic             idex_mem_read,
    input  logic [2:0]       idex_write_reg,
    input  logic             idex_wr_valid,
    input  logic             ex_redirect,
    input  logic             id_halt,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             controlZero,
    output logic             pipe_write_en,
    output logic             pipe_halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LDUSE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [DCW-1:0]   drain_cnt_reg, drain_cnt_next;
    logic [CNT_W-1:0] stall_cycles_reg;

    logic [2:0] src_reg [2];
    logic [1:0] src_valid;
    logic [1:0] src_match;
    logic       hazard;

    logic pc_we_c, ifid_we_c, flush_c, cz_c, pwe_c;
    logic count_stall;

    assign src_reg[0]   = id_Rs;
    assign src_reg[1]   = id_Rt;
    assign src_valid[0] = id_RsValid;
    assign src_valid[1] = id_RtValid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_valid[gi] && (src_reg[gi] == idex_write_reg);
        end
    endgenerate

    assign hazard = idex_mem_read && idex_wr_valid && (|src_match);

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        pc_we_c        = 1'b1;
        ifid_we_c      = 1'b1;
        flush_c        = 1'b0;
        cz_c           = 1'b0;
        pwe_c          = 1'b1;

        case (state_reg)
            ST_RUN, ST_LDUSE: begin
                if (dmem_stall) begin
                    // Whole-pipe freeze; any redirect is re-presented once EX moves again.
                    pc_we_c   = 1'b0;
                    ifid_we_c = 1'b0;
                    pwe_c     = 1'b0;
                end else if (ex_redirect) begin
                    flush_c    = 1'b1;
                    cz_c       = 1'b1;
                    state_next = ST_RUN;
                end else if ((state_reg == ST_RUN) && id_halt) begin
                    pc_we_c        = 1'b0;
                    ifid_we_c      = 1'b0;
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end else if ((state_reg == ST_RUN) && hazard) begin
                    pc_we_c    = 1'b0;
                    ifid_we_c  = 1'b0;
                    cz_c       = 1'b1;
                    state_next = ST_LDUSE;
                end else begin
                    if (imem_stall) begin
                        pc_we_c = 1'b0;
                        flush_c = 1'b1;
                    end
                    state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_we_c = 1'b0;
                flush_c = 1'b1;
                cz_c    = 1'b1;
                pwe_c   = !dmem_stall;
                if (!dmem_stall) begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_next = ST_HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + DCW'(1);
                    end
                end
            end
            default: begin
                pc_we_c   = 1'b0;
                ifid_we_c = 1'b0;
                pwe_c     = 1'b0;
                flush_c   = 1'b1;
                cz_c      = 1'b1;
            end
        endcase

        if (rst) begin
            pc_we_c   = 1'b0;
            ifid_we_c = 1'b0;
            flush_c   = 1'b1;
            cz_c      = 1'b1;
        end
    end

    assign count_stall = !rst && !pc_we_c &&
                         ((state_reg == ST_RUN) || (state_reg == ST_LDUSE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            drain_cnt_reg    <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            if (count_stall && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
        end
    end

    assign pc_write_en   = pc_we_c;
    assign ifid_write_en = ifid_we_c;
    assign ifid_flush    = flush_c;
    assign controlZero   = cz_c;
    assign pipe_write_en = pwe_c;
    assign pipe_halted   = (state_reg == ST_HALTED);
    assign stall_cycles  = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a pipeline-level model predicts each cycle's
// control outputs; a negedge monitor pops and compares against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    id_Rs, id_Rt, idex_write_reg;
    logic          id_RsValid, id_RtValid, idex_mem_read, idex_wr_valid;
    logic          ex_redirect, id_halt, imem_stall, dmem_stall;
    logic          pc_write_en, ifid_write_en, ifid_flush, controlZero;
    logic          pipe_write_en, pipe_halted;
    logic [CW-1:0] stall_cycles;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_Rs(id_Rs), .id_Rt(id_Rt), .id_RsValid(id_RsValid), .id_RtValid(id_RtValid),
        .idex_mem_read(idex_mem_read), .idex_write_reg(idex_write_reg),
        .idex_wr_valid(idex_wr_valid), .ex_redirect(ex_redirect), .id_halt(id_halt),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
        .controlZero(controlZero), .pipe_write_en(pipe_write_en), .pipe_halted(pipe_halted),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit       r;
        bit [2:0] rs, rt, wr;
        bit       rsv, rtv, mr, wv, red, halt, ims, dms;
    } in_t;

    typedef struct {
        int       id;
        bit       full;
        bit [3:0] ctl;   // {pc_we, ifid_we, flush, controlZero}
        bit       pwe, hl;
        int       cnt;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;
    int txn        = 0;

    // Model: pipeline mode, remaining drain cycles and stall tally
    int mode;        // 0 running, 1 bubble just issued, 2 draining, 3 halted
    int drain_left;
    int tally;

    function automatic in_t idle();
        in_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input in_t s);
        exp_t e;
        bit   load_use;
        @(posedge clk);
        #1;
        rst = s.r; id_Rs = s.rs; id_Rt = s.rt; idex_write_reg = s.wr;
        id_RsValid = s.rsv; id_RtValid = s.rtv; idex_mem_read = s.mr; idex_wr_valid = s.wv;
        ex_redirect = s.red; id_halt = s.halt; imem_stall = s.ims; dmem_stall = s.dms;

        load_use = s.mr && s.wv && ((s.rsv && s.rs == s.wr) || (s.rtv && s.rt == s.wr));
        e.id = txn; txn++;
        e.full = !s.r;
        e.cnt = tally;
        e.hl = (mode == 3);
        e.pwe = 1'b1;
        if (s.r) begin
            e.ctl = 4'b0011;
            mode = 0; drain_left = 0; tally = 0;
        end else if (mode == 3) begin
            e.ctl = 4'b0011; e.pwe = 1'b0;
        end else if (mode == 2) begin
            e.ctl = 4'b0111; e.pwe = !s.dms;
            if (!s.dms) begin
                drain_left = drain_left - 1;
                if (drain_left == 0) mode = 3;
            end
        end else begin
            if (s.dms) begin
                e.ctl = 4'b0000; e.pwe = 1'b0;
            end else if (s.red) begin
                e.ctl = 4'b1111; mode = 0;
            end else if (mode == 0 && s.halt) begin
                e.ctl = 4'b0000; mode = 2; drain_left = DRAIN;
            end else if (mode == 0 && load_use) begin
                e.ctl = 4'b0001; mode = 1;
            end else if (s.ims) begin
                e.ctl = 4'b0110; mode = 0;
            end else begin
                e.ctl = 4'b1100; mode = 0;
            end
            if (!e.ctl[3] && tally < CMAX) tally = tally + 1;
        end
        sb.push_back(e);
    endtask

    task automatic rnd_step();
        in_t s;
        s.r    = ($urandom_range(0, 99) < 2);
        s.rs   = 3'($urandom_range(0, 3));
        s.rt   = 3'($urandom_range(0, 3));
        s.wr   = 3'($urandom_range(0, 3));
        s.rsv  = ($urandom_range(0, 99) < 70);
        s.rtv  = ($urandom_range(0, 99) < 50);
        s.mr   = ($urandom_range(0, 99) < 40);
        s.wv   = ($urandom_range(0, 99) < 80);
        s.red  = ($urandom_range(0, 99) < 10);
        s.halt = ($urandom_range(0, 99) < 4);
        s.ims  = ($urandom_range(0, 99) < 15);
        s.dms  = ($urandom_range(0, 99) < 15);
        step(s);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle
    initial begin
        exp_t     e;
        bit [3:0] act;
        bit       ok;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {pc_write_en, ifid_write_en, ifid_flush, controlZero};
                ok = (act == e.ctl);
                if (e.full)
                    ok = ok && (pipe_write_en == e.pwe) && (pipe_halted == e.hl) &&
                         (int'(stall_cycles) == e.cnt);
                compared++;
                if (!ok) begin
                    mismatched++;
                    $display("FAIL txn%0d ctl/pwe/halt/cnt: got %b/%b/%b/%0d required %b/%b/%b/%0d%s",
                             e.id, act, pipe_write_en, pipe_halted, stall_cycles,
                             e.ctl, e.pwe, e.hl, e.cnt, e.full ? "" : " (reset: ctl only)");
                end else begin
                    $display("txn%0d ok ctl=%b pwe=%b halt=%b cnt=%0d", e.id, act,
                             pipe_write_en, pipe_halted, stall_cycles);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t s;
        rst = 1'b1; id_Rs = '0; id_Rt = '0; idex_write_reg = '0;
        id_RsValid = 0; id_RtValid = 0; idex_mem_read = 0; idex_wr_valid = 0;
        ex_redirect = 0; id_halt = 0; imem_stall = 0; dmem_stall = 0;
        mode = 0; drain_left = 0; tally = 0;

        s = idle(); s.r = 1; step(s); step(s);
        step(idle());

        // T1 load-use on Rs, then T2 same operands but no sources read
        s = idle(); s.mr = 1; s.wv = 1; s.wr = 3'd2; s.rs = 3'd2; s.rsv = 1;
        step(s); step(idle()); step(idle());
        s.rsv = 0; s.rtv = 0; step(s); step(idle());

        // T3 redirect kills hazard and halt
        s = idle(); s.mr = 1; s.wv = 1; s.wr = 3'd5; s.rt = 3'd5; s.rtv = 1;
        s.red = 1; s.halt = 1; step(s); step(idle());

        // T5 bubble frozen by 4 dmem stalls
        s = idle(); s.mr = 1; s.wv = 1; s.wr = 3'd1; s.rs = 3'd1; s.rsv = 1;
        step(s);
        s = idle(); s.dms = 1; repeat (4) step(s);
        step(idle()); step(idle());

        // T4 halt with 2 stalled drain cycles, then sticky halted
        s = idle(); s.halt = 1; step(s);
        s = idle(); step(s); s.dms = 1; step(s); s.dms = 0; step(s);
        s.dms = 1; step(s); s.dms = 0; step(s);
        s = idle(); s.red = 1; repeat (4) step(s);
        s = idle(); s.r = 1; step(s); step(idle());

        // T6 saturation of the stall counter, then reset mid-drain
        s = idle(); s.dms = 1; repeat (CMAX + 3) step(s);
        s = idle(); s.halt = 1; step(s); step(idle());
        s = idle(); s.r = 1; step(s);
        step(idle()); step(idle());

        s = idle(); s.r = 1; step(s);
        repeat (1500) rnd_step();

        repeat (3) @(posedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain_queue: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
